dma_io_responder: RTL and testbench

- Peripheral-side DMA handshake agent: the I/O device end of the DREQ/DACK/IOR/IOW/EOP protocol driven by the DMA timing control FSM.
- Buffers local data in a FIFO and raises DREQ when a transfer is warranted.
- Sources the data bus on IOR_N (device-to-memory) or captures it on IOW_N (memory-to-device).
- Tracks terminal count via EOP_N.

---
 rtl/dma_io_responder.sv | 213 +++++++++++++++++++++
 tb/tb_dma_io_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_io_responder.sv
// I/O-device end of the DREQ/DACK/IOR/IOW/EOP DMA handshake, with a local FIFO that
// sources read cycles (DIR=0) or sinks write cycles (DIR=1).
module dma_io_responder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int THRESH = 1
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    ENABLE,
    input  logic                    DIR,
    input  logic                    FLUSH,
    output logic                    DREQ,
    input  logic                    DACK_N,
    input  logic                    IOR_N,
    input  logic                    IOW_N,
    input  logic                    EOP_N,
    input  logic [DATA_W-1:0]       DB_IN,
    output logic [DATA_W-1:0]       DB_OUT,
    output logic                    DB_OE,
    input  logic                    LWR_VALID,
    output logic                    LWR_READY,
    input  logic [DATA_W-1:0]       LWR_DATA,
    output logic                    LRD_VALID,
    input  logic                    LRD_READY,
    output logic [DATA_W-1:0]       LRD_DATA,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    DONE,
    output logic                    UNDERRUN,
    output logic                    OVERRUN
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] THRESH_L = LW'(THRESH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_ACK  = 3'd2,
        S_XFER = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              ior_q_r, iow_q_r, eop_flag_r, dreq_r, done_r, underrun_r, overrun_r;
    logic [DATA_W-1:0] cap_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]     level_r, level_nxt_s;
    logic              full_s, empty_s, req_ok_s, in_bus_s;
    logic              strobe_pin_s, strobe_hist_s, strobe_fall_s, strobe_rise_s;
    logic              commit_s, eop_set_s, eop_now_s;
    logic              lwr_push_s, lrd_pop_s, bus_pop_s, bus_push_s, push_s, pop_s;
    logic              underrun_set_s, overrun_set_s;
    logic [DATA_W-1:0] head_s, push_data_s;

    assign full_s  = (level_r == DEPTH_L);
    assign empty_s = (level_r == LW'(0));
    assign head_s  = empty_s ? DATA_W'(0) : mem_r[rd_ptr_r];

    // The strobe that matters follows DIR; edges come from a one-deep history.
    assign strobe_pin_s  = DIR ? IOW_N : IOR_N;
    assign strobe_hist_s = DIR ? iow_q_r : ior_q_r;
    assign strobe_fall_s = strobe_hist_s & ~strobe_pin_s;
    assign strobe_rise_s = ~strobe_hist_s & strobe_pin_s;

    assign in_bus_s  = (state_r == S_ACK) || (state_r == S_XFER);
    assign commit_s  = (state_r == S_XFER) & strobe_rise_s & ~DACK_N;
    assign eop_set_s = in_bus_s & ~DACK_N & ~EOP_N;
    assign eop_now_s = eop_flag_r | eop_set_s;

    // A full FIFO still accepts a bus word when the local side pops in the same cycle.
    assign lwr_push_s     = LWR_VALID & ~full_s & ~DIR;
    assign lrd_pop_s      = LRD_READY & ~empty_s & DIR;
    assign bus_pop_s      = commit_s & ~DIR & ~empty_s;
    assign bus_push_s     = commit_s & DIR & (~full_s | lrd_pop_s);
    assign push_s         = lwr_push_s | bus_push_s;
    assign pop_s          = bus_pop_s | lrd_pop_s;
    assign push_data_s    = DIR ? cap_r : LWR_DATA;
    assign underrun_set_s = commit_s & ~DIR & empty_s;
    assign overrun_set_s  = commit_s & DIR & full_s & ~lrd_pop_s;

    assign DREQ      = dreq_r;
    assign DONE      = done_r;
    assign UNDERRUN  = underrun_r;
    assign OVERRUN   = overrun_r;
    assign LEVEL     = level_r;
    assign DB_OUT    = head_s;
    assign DB_OE     = ~DIR & ~DACK_N & ~IOR_N & in_bus_s;
    assign LWR_READY = ~full_s & ~DIR;
    assign LRD_VALID = ~empty_s & DIR;
    assign LRD_DATA  = head_s;

    // Occupancy after this cycle's pushes, pops and flush
    always_comb begin
        level_nxt_s = level_r;
        if (FLUSH) begin
            level_nxt_s = LW'(0);
        end else begin
            level_nxt_s = level_r + LW'(push_s) - LW'(pop_s);
        end
    end

    // Request qualification against the post-operation occupancy
    always_comb begin
        req_ok_s = 1'b0;
        if (ENABLE && !done_r) begin
            if (DIR) begin
                req_ok_s = (DEPTH_L - level_nxt_s) >= THRESH_L;
            end else begin
                req_ok_s = level_nxt_s >= THRESH_L;
            end
        end else begin
            req_ok_s = 1'b0;
        end
    end

    // Handshake next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_ok_s) state_nxt_s = S_REQ;
                else          state_nxt_s = S_IDLE;
            end
            S_REQ: begin
                if (!ENABLE)        state_nxt_s = S_IDLE;
                else if (!EOP_N)    state_nxt_s = S_DONE;
                else if (!req_ok_s) state_nxt_s = S_IDLE;
                else if (!DACK_N)   state_nxt_s = S_ACK;
                else                state_nxt_s = S_REQ;
            end
            S_ACK: begin
                if (!ENABLE)                     state_nxt_s = S_IDLE;
                else if (DACK_N)                 state_nxt_s = S_REQ;
                else if (strobe_fall_s)          state_nxt_s = S_XFER;
                else if (!EOP_N && strobe_pin_s) state_nxt_s = S_DONE;
                else                             state_nxt_s = S_ACK;
            end
            S_XFER: begin
                // A commit always happens with DACK_N low, so a continuing burst re-enters ACK.
                if (commit_s) begin
                    if (eop_now_s)     state_nxt_s = S_DONE;
                    else if (req_ok_s) state_nxt_s = S_ACK;
                    else               state_nxt_s = S_IDLE;
                end else if (DACK_N) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_XFER;
                end
            end
            S_DONE: begin
                if (!ENABLE) state_nxt_s = S_IDLE;
                else         state_nxt_s = S_DONE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Strobe history, write-data capture, FSM state and its registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ior_q_r    <= 1'b1;
            iow_q_r    <= 1'b1;
            cap_r      <= DATA_W'(0);
            state_r    <= S_IDLE;
            dreq_r     <= 1'b0;
            done_r     <= 1'b0;
            eop_flag_r <= 1'b0;
        end else begin
            ior_q_r <= IOR_N;
            iow_q_r <= IOW_N;
            if (DIR && (state_r == S_XFER) && !IOW_N) cap_r <= DB_IN;
            state_r <= state_nxt_s;
            dreq_r  <= (state_nxt_s == S_REQ) || (state_nxt_s == S_ACK) || (state_nxt_s == S_XFER);
            done_r  <= (state_nxt_s == S_DONE);
            if (((state_nxt_s == S_ACK) || (state_nxt_s == S_XFER)) && !commit_s) begin
                eop_flag_r <= eop_now_s;
            end else begin
                eop_flag_r <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and sticky error flags
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            level_r    <= LW'(0);
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else if (FLUSH) begin
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            level_r    <= LW'(0);
            underrun_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            level_r <= level_nxt_s;
            if (underrun_set_s) underrun_r <= 1'b1;
            if (overrun_set_s)  overrun_r  <= 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge CLK) begin
        if (push_s && !FLUSH) mem_r[wr_ptr_r] <= push_data_s;
    end
endmodule

// File: tb/tb_dma_io_responder.sv
// Self-checking bench for dma_io_responder: vector table, directed corner cases and
// a randomized DIR=0 phase checked against a queue model of the FIFO.
module tb_dma_io_responder;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       enable = 1'b0, dir = 1'b0, flush = 1'b0;
    logic       dack_n = 1'b1, ior_n = 1'b1, iow_n = 1'b1, eop_n = 1'b1;
    logic [7:0] db_in = 8'd0, lwr_data = 8'd0;
    logic       lwr_valid = 1'b0, lrd_ready = 1'b0;
    logic       dreq, db_oe, lwr_ready, lrd_valid, done, underrun, overrun;
    logic [7:0] db_out, lrd_data;
    logic [3:0] level;

    typedef struct {
        logic [7:0] data;
        logic [3:0] exp_level;
        logic       exp_dreq;
    } wr_vec_t;
    wr_vec_t    vec [8];
    logic [7:0] q [$];
    int         checks = 0, errors = 0;

    dma_io_responder #(.DATA_W(8), .DEPTH(8), .THRESH(1)) dut (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .DIR(dir), .FLUSH(flush),
        .DREQ(dreq), .DACK_N(dack_n), .IOR_N(ior_n), .IOW_N(iow_n), .EOP_N(eop_n),
        .DB_IN(db_in), .DB_OUT(db_out), .DB_OE(db_oe),
        .LWR_VALID(lwr_valid), .LWR_READY(lwr_ready), .LWR_DATA(lwr_data),
        .LRD_VALID(lrd_valid), .LRD_READY(lrd_ready), .LRD_DATA(lrd_data),
        .LEVEL(level), .DONE(done), .UNDERRUN(underrun), .OVERRUN(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_dreq(input string name, input int budget);
        int n = 0;
        while (dreq !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(dreq), 32'd1);
    endtask

    task automatic lpush(input logic [7:0] d);
        lwr_valid = 1'b1;
        lwr_data  = d;
        step();
        lwr_valid = 1'b0;
    endtask

    // One IOR cycle, entered from ACK with DACK_N already low; strobe held low for 3 clocks.
    task automatic bus_read(input string name, input logic [7:0] exp, input logic eop,
                            input logic also_push, input logic [7:0] pd);
        ior_n = 1'b0;
        eop_n = ~eop;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk({name, "_oe"}, 32'(db_oe), 32'd1);
            chk({name, "_data"}, 32'(db_out), 32'(exp));
            step();
        end
        ior_n = 1'b1;
        if (also_push) begin
            lwr_valid = 1'b1;
            lwr_data  = pd;
        end
        step();
        lwr_valid = 1'b0;
        eop_n     = 1'b1;
    endtask

    // Bring a full FIFO into XFER via a read cycle, then turn it around into a write commit.
    task automatic full_commit(input string name, input logic pop, input logic [7:0] exp_head,
                               input logic exp_ovr);
        enable = 1'b1;
        wait_dreq({name, "_dreq"}, 4);
        dack_n = 1'b0;
        step();
        ior_n = 1'b0;
        step();
        enable = 1'b0;
        dir    = 1'b1;
        ior_n  = 1'b1;
        iow_n  = 1'b0;
        db_in  = 8'hC3;
        step();
        chk({name, "_head"}, 32'(lrd_data), 32'(exp_head));
        iow_n     = 1'b1;
        lrd_ready = pop;
        step();
        lrd_ready = 1'b0;
        dack_n    = 1'b1;
        chk({name, "_level"}, 32'(level), 32'd8);
        chk({name, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        chk({name, "_dreq_low"}, 32'(dreq), 32'd0);
        dir = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vec[i].data      = 8'(i + 1);
            vec[i].exp_level = 4'(i + 1);
            vec[i].exp_dreq  = (i < 7);
        end

        // Reset values
        step();
        chk("rst_dreq", 32'(dreq), 32'd0);
        chk("rst_db_oe", 32'(db_oe), 32'd0);
        chk("rst_db_out", 32'(db_out), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_flags", {29'd0, done, underrun, overrun}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single read cycle of 0xA5
        lpush(8'hA5);
        enable = 1'b1;
        wait_dreq("t1_dreq", 2);
        dack_n = 1'b0;
        step();
        bus_read("t1", 8'hA5, 1'b0, 1'b0, 8'h00);
        chk("t1_level", 32'(level), 32'd0);
        chk("t1_dreq_low", 32'(dreq), 32'd0);
        dack_n = 1'b1;
        enable = 1'b0;
        step();

        // Demand-mode write burst until full, from the vector table
        dir    = 1'b1;
        enable = 1'b1;
        wait_dreq("t2_dreq", 2);
        dack_n = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            iow_n = 1'b0;
            db_in = vec[i].data;
            step();
            step();
            iow_n = 1'b1;
            step();
            chk($sformatf("t2_level_%0d", i), 32'(level), 32'(vec[i].exp_level));
            chk($sformatf("t2_dreq_%0d", i), 32'(dreq), 32'(vec[i].exp_dreq));
        end
        dack_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_lrd_%0d", i), {23'd0, lrd_valid, lrd_data}, {23'd0, 1'b1, vec[i].data});
            lrd_ready = 1'b1;
            step();
            lrd_ready = 1'b0;
        end
        enable = 1'b0;
        step();
        chk("t2_empty", 32'(level), 32'd0);

        // Burst of three reads, terminal count on the third
        dir = 1'b0;
        step();
        lpush(8'h11);
        lpush(8'h22);
        lpush(8'h33);
        enable = 1'b1;
        wait_dreq("t3_dreq", 2);
        dack_n = 1'b0;
        step();
        bus_read("t3a", 8'h11, 1'b0, 1'b0, 8'h00);
        bus_read("t3b", 8'h22, 1'b0, 1'b0, 8'h00);
        bus_read("t3c", 8'h33, 1'b1, 1'b0, 8'h00);
        dack_n = 1'b1;
        step();
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_dreq_low", 32'(dreq), 32'd0);
        chk("t3_level", 32'(level), 32'd0);
        enable = 1'b0;
        step();
        chk("t3_done_clr", 32'(done), 32'd0);

        // DACK_N withdrawn mid-strobe: no commit
        lpush(8'h44);
        lpush(8'h55);
        enable = 1'b1;
        wait_dreq("t4_dreq", 2);
        dack_n = 1'b0;
        step();
        ior_n = 1'b0;
        step();
        step();
        dack_n = 1'b1;
        step();
        chk("t4_level", 32'(level), 32'd2);
        chk("t4_dreq", 32'(dreq), 32'd1);
        chk("t4_oe_low", 32'(db_oe), 32'd0);
        ior_n = 1'b1;
        step();
        chk("t4_no_pop", 32'(level), 32'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush", 32'(level), 32'd0);
        chk("t4_flush_dreq", 32'(dreq), 32'd0);
        enable = 1'b0;
        step();

        // Write commit against a full FIFO, with and without a same-cycle local pop
        for (int i = 0; i < 8; i++) lpush(8'(8'h60 + i));
        full_commit("t5a", 1'b1, 8'h60, 1'b0);
        chk("t5a_next_head", 32'(lrd_data), 32'h61);
        full_commit("t5b", 1'b0, 8'h61, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_ovr", 32'(overrun), 32'd0);
        chk("t5_flush_level", 32'(level), 32'd0);

        // Read commit against an empty FIFO
        dir    = 1'b1;
        enable = 1'b1;
        wait_dreq("t6_dreq", 2);
        dack_n = 1'b0;
        step();
        iow_n = 1'b0;
        step();
        enable = 1'b0;
        dir    = 1'b0;
        iow_n  = 1'b1;
        ior_n  = 1'b0;
        step();
        chk("t6_db_out_empty", 32'(db_out), 32'd0);
        ior_n = 1'b1;
        step();
        dack_n = 1'b1;
        chk("t6_underrun", 32'(underrun), 32'd1);
        chk("t6_level", 32'(level), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_underrun_clr", 32'(underrun), 32'd0);

        // Randomized DIR=0 traffic against the queue model
        q.delete();
        enable = 1'b1;
        step();
        for (int it = 0; it < 60; it++) begin
            int op;
            op = $urandom_range(0, 4);
            if (op <= 1) begin
                if (q.size() < 8) begin
                    logic [7:0] d;
                    d = 8'($urandom());
                    chk("rnd_lwr_ready", 32'(lwr_ready), 32'd1);
                    lpush(d);
                    q.push_back(d);
                end else begin
                    chk("rnd_lwr_full", 32'(lwr_ready), 32'd0);
                end
            end else if (op <= 3) begin
                if (q.size() > 0) begin
                    logic       ap;
                    logic [7:0] pd;
                    ap = (q.size() < 8) && ($urandom_range(0, 1) == 1);
                    pd = 8'($urandom());
                    chk("rnd_req", 32'(dreq), 32'd1);
                    dack_n = 1'b0;
                    step();
                    bus_read("rnd_rd", q[0], 1'b0, ap, pd);
                    dack_n = 1'b1;
                    void'(q.pop_front());
                    if (ap) q.push_back(pd);
                end
            end else begin
                if ($urandom_range(0, 2) == 0) begin
                    flush = 1'b1;
                    step();
                    flush = 1'b0;
                    q.delete();
                end
            end
            step();
            chk("rnd_level", 32'(level), 32'(q.size()));
            chk("rnd_dreq", 32'(dreq), 32'(q.size() >= 1));
        end
        enable = 1'b0;
        flush  = 1'b1;
        step();
        flush = 1'b0;

        // Asynchronous reset in the middle of a read strobe
        lpush(8'h77);
        lpush(8'h88);
        enable = 1'b1;
        wait_dreq("t7_dreq", 2);
        dack_n = 1'b0;
        step();
        ior_n = 1'b0;
        step();
        step();
        chk("t7_oe_before", 32'(db_oe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_dreq", 32'(dreq), 32'd0);
        chk("t7_rst_oe", 32'(db_oe), 32'd0);
        chk("t7_rst_level", 32'(level), 32'd0);
        ior_n  = 1'b1;
        dack_n = 1'b1;
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t7_after_level", 32'(level), 32'd0);
        chk("t7_after_dreq", 32'(dreq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
